// File: rtl/sdram_wr_burst_ctrl.sv
// SDRAM write-burst engine: splits a request at page ends and walks row/bank, sequencing
// ACTIVE / WRITE / BURST_STOP / PRECHARGE under tRCD, tWR and tRP. sdram_* registered, wr_ack combinational.
module sdram_wr_burst_ctrl #(
  parameter int DATA_W = 16,
  parameter int BA_W   = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int LEN_W  = 11,
  parameter int TRCD   = 2,
  parameter int TWR    = 2,
  parameter int TRP    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         init_end_i,
  input  logic                         wr_req_i,
  input  logic [BA_W+ROW_W+COL_W-1:0]  wr_addr_i,
  input  logic [LEN_W-1:0]             wr_len_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  output logic                         wr_ack_o,
  output logic                         wr_done_o,
  output logic                         busy_o,
  output logic [3:0]                   sdram_cmd_o,
  output logic [BA_W-1:0]              sdram_ba_o,
  output logic [ROW_W-1:0]             sdram_addr_o,
  output logic                         sdram_dq_oe_o,
  output logic [DATA_W-1:0]            sdram_dq_o
);
  localparam int SEG_W = LEN_W + 1;
  localparam int BR_W  = BA_W + ROW_W;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_STOP  = 4'b0110;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [SEG_W-1:0] PAGE     = SEG_W'(2 ** COL_W);
  localparam logic [SEG_W-1:0] TRCD_END = SEG_W'((TRCD > 1) ? TRCD - 2 : 0);
  localparam logic [SEG_W-1:0] TWR_END  = SEG_W'((TWR > 1) ? TWR - 2 : 0);
  localparam logic [SEG_W-1:0] TRP_END  = SEG_W'((TRP > 1) ? TRP - 2 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_TRCD, S_WR, S_DATA, S_TWR, S_PRE, S_TRP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BA_W-1:0]    bank_q, bank_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [SEG_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [BA_W-1:0]    ba_q, ba_d;
  logic [ROW_W-1:0]   addr_q, addr_d;
  logic               dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0]  dq_q, dq_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [SEG_W-1:0]   page_left, rem_ext, seg_calc;
  logic [LEN_W-1:0]   rem_after;
  logic               accept;

  assign page_left = PAGE - SEG_W'(col_q);
  assign rem_ext   = SEG_W'(rem_q);
  assign seg_calc  = (rem_ext < page_left) ? rem_ext : page_left;
  assign rem_after = rem_q - seg_q[LEN_W-1:0];
  assign accept    = init_end_i && wr_req_i && (wr_len_i != '0);

  // One strobe in WR, then seg-1 more in DATA; the final DATA cycle only issues BURST_STOP.
  assign wr_ack_o = (state_q == S_WR) ||
                    ((state_q == S_DATA) && ((cnt_q + SEG_W'(1)) < seg_q));

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    rem_d   = rem_q;
    seg_d   = seg_q;
    cnt_d   = cnt_q;
    cmd_d   = CMD_NOP;
    ba_d    = '1;
    addr_d  = '1;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          {bank_d, row_d, col_d} = wr_addr_i;
          rem_d   = wr_len_i;
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        cmd_d   = CMD_ACT;
        ba_d    = bank_q;
        addr_d  = row_q;
        seg_d   = seg_calc;
        cnt_d   = '0;
        state_d = (TRCD > 1) ? S_TRCD : S_WR;
      end
      S_TRCD: begin
        cnt_d = cnt_q + SEG_W'(1);
        if (cnt_q == TRCD_END) begin
          cnt_d   = '0;
          state_d = S_WR;
        end
      end
      S_WR: begin
        cmd_d   = CMD_WRITE;
        ba_d    = bank_q;
        addr_d  = {{(ROW_W-COL_W){1'b0}}, col_q};
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = cnt_q + SEG_W'(1);
        if (cnt_q == seg_q - SEG_W'(1)) begin
          cmd_d   = CMD_STOP;
          cnt_d   = '0;
          state_d = (TWR > 1) ? S_TWR : S_PRE;
        end
      end
      S_TWR: begin
        cnt_d = cnt_q + SEG_W'(1);
        if (cnt_q == TWR_END) begin
          cnt_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        cmd_d           = CMD_PRE;
        ba_d            = bank_q;
        addr_d          = '0;
        rem_d           = rem_after;
        col_d           = '0;
        {bank_d, row_d} = {bank_q, row_q} + BR_W'(1);
        cnt_d           = '0;
        if (TRP > 1)                state_d = S_TRP;
        else if (rem_after == '0)   state_d = S_DONE;
        else                        state_d = S_ACT;
      end
      S_TRP: begin
        cnt_d = cnt_q + SEG_W'(1);
        if (cnt_q == TRP_END) begin
          cnt_d   = '0;
          state_d = (rem_q == '0) ? S_DONE : S_ACT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    dq_oe_d = wr_ack_o;
    dq_d    = wr_ack_o ? wr_data_i : '0;
    done_d  = (state_q == S_DONE);
    // Keep busy through the wr_done cycle even when the FSM is already back in IDLE.
    busy_d  = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rem_q   <= '0;
      seg_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '1;
      addr_q  <= '1;
      dq_oe_q <= 1'b0;
      dq_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rem_q   <= rem_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      dq_oe_q <= dq_oe_d;
      dq_q    <= dq_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign sdram_cmd_o   = cmd_q;
  assign sdram_ba_o    = ba_q;
  assign sdram_addr_o  = addr_q;
  assign sdram_dq_oe_o = dq_oe_q;
  assign sdram_dq_o    = dq_q;
  assign wr_done_o     = done_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Scoreboard bench: each request pushes its cycle-exact command/data trace; a negedge monitor
// pops and compares every cycle in which the DUT drives anything other than idle values.
module tb_sdram_wr_burst_ctrl;
  localparam int TRCD = 2;
  localparam int TWR  = 2;
  localparam int TRP  = 2;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_WR   = 4'b0100;
  localparam logic [3:0] C_STOP = 4'b0110;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_NOP  = 4'b0111;

  logic        clk_i = 1'b0;
  logic        rst_i, init_end_i, wr_req_i;
  logic [23:0] wr_addr_i;
  logic [10:0] wr_len_i;
  logic [15:0] wr_data_i;
  logic        wr_ack_o, wr_done_o, busy_o, sdram_dq_oe_o;
  logic [3:0]  sdram_cmd_o;
  logic [1:0]  sdram_ba_o;
  logic [12:0] sdram_addr_o;
  logic [15:0] sdram_dq_o;

  sdram_wr_burst_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .init_end_i(init_end_i), .wr_req_i(wr_req_i),
    .wr_addr_i(wr_addr_i), .wr_len_i(wr_len_i), .wr_data_i(wr_data_i),
    .wr_ack_o(wr_ack_o), .wr_done_o(wr_done_o), .busy_o(busy_o),
    .sdram_cmd_o(sdram_cmd_o), .sdram_ba_o(sdram_ba_o), .sdram_addr_o(sdram_addr_o),
    .sdram_dq_oe_o(sdram_dq_oe_o), .sdram_dq_o(sdram_dq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] cyc;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        oe;
    logic [15:0] dq;
    logic        done;
    logic        busy;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          ack_total = 0;
  logic [15:0] exp_word = 16'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic ev_t mk(input int c, input logic [3:0] cmd, input logic [1:0] ba,
                             input logic [12:0] addr, input logic oe, input logic [15:0] dq,
                             input logic done);
    ev_t e;
    e.cyc = 16'(c); e.cmd = cmd; e.ba = ba; e.addr = addr;
    e.oe = oe; e.dq = dq; e.done = done; e.busy = 1'b1;
    return e;
  endfunction

  // Expected trace of one request accepted at posedge number e_edge.
  task automatic model_req(input logic [1:0] ba, input logic [12:0] row, input logic [8:0] col,
                           input int len, input int e_edge, output int done_cyc);
    int a, rem, seg, w;
    logic [1:0]  b;
    logic [12:0] r;
    logic [8:0]  c;
    b = ba; r = row; c = col; rem = len; a = e_edge + 1;
    while (rem > 0) begin
      seg = (rem < 512 - int'(c)) ? rem : 512 - int'(c);
      exp_q.push_back(mk(a, C_ACT, b, r, 1'b0, 16'h0, 1'b0));
      w = a + TRCD;
      for (int k = 0; k < seg; k++) begin
        if (k == 0) exp_q.push_back(mk(w, C_WR, b, {4'b0, c}, 1'b1, exp_word, 1'b0));
        else        exp_q.push_back(mk(w + k, C_NOP, 2'b11, 13'h1FFF, 1'b1, exp_word, 1'b0));
        exp_word++;
      end
      exp_q.push_back(mk(w + seg, C_STOP, 2'b11, 13'h1FFF, 1'b0, 16'h0, 1'b0));
      exp_q.push_back(mk(w + seg + TWR, C_PRE, b, 13'h0, 1'b0, 16'h0, 1'b0));
      a = w + seg + TWR + TRP;
      rem -= seg;
      {b, r} = {b, r} + 15'd1;
      c = 9'd0;
    end
    exp_q.push_back(mk(a, C_NOP, 2'b11, 13'h1FFF, 1'b0, 16'h0, 1'b1));
    done_cyc = a;
  endtask

  task automatic issue(input logic [1:0] ba, input logic [12:0] row, input logic [8:0] col,
                       input int len, input bit hold, output int done_cyc);
    int e_edge;
    @(posedge clk_i); #1;
    wr_addr_i = {ba, row, col};
    wr_len_i  = 11'(len);
    wr_req_i  = 1'b1;
    e_edge    = cyc + 1;
    model_req(ba, row, col, len, e_edge, done_cyc);
    if (!hold) begin
      @(posedge clk_i); #1;
      wr_req_i = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_i); #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd"},  64'(sdram_cmd_o),   64'(C_NOP));
    check({tag, "_ba"},   64'(sdram_ba_o),    64'h3);
    check({tag, "_addr"}, 64'(sdram_addr_o),  64'h1FFF);
    check({tag, "_oe"},   64'(sdram_dq_oe_o), 64'd0);
    check({tag, "_dq"},   64'(sdram_dq_o),    64'd0);
    check({tag, "_ack"},  64'(wr_ack_o),      64'd0);
    check({tag, "_done"}, 64'(wr_done_o),     64'd0);
    check({tag, "_busy"}, 64'(busy_o),        64'd0);
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Word source: presents ack_total+1 and advances after each consumed word.
  initial begin
    logic a;
    wr_data_i = 16'd1;
    forever begin
      @(negedge clk_i);
      a = wr_ack_o;
      @(posedge clk_i); #1;
      if (a) begin
        ack_total++;
        wr_data_i = 16'(ack_total + 1);
      end
    end
  end

  initial begin
    ev_t act;
    forever begin
      @(negedge clk_i);
      if ((sdram_cmd_o != C_NOP) || sdram_dq_oe_o || wr_done_o || (sdram_ba_o != 2'b11) ||
          (sdram_addr_o != 13'h1FFF) || (sdram_dq_o != 16'h0)) begin
        act      = mk(cyc, sdram_cmd_o, sdram_ba_o, sdram_addr_o, sdram_dq_oe_o, sdram_dq_o, wr_done_o);
        act.busy = busy_o;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_event: got %h expected no activity (cycle %0d)", act, cyc);
        end else begin
          check("event", 64'(act), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int d1, d2, a0, e_edge;
    rst_i = 1'b1; init_end_i = 1'b0; wr_req_i = 1'b0; wr_addr_i = '0; wr_len_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_idle_outputs("reset");
    rst_i = 1'b0;

    // No accept while init is pending, nor for a zero-length request.
    wr_addr_i = {2'd1, 13'h010, 9'h000}; wr_len_i = 11'd4; wr_req_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    check("noinit_busy", 64'(busy_o), 64'd0);
    check("noinit_cmd", 64'(sdram_cmd_o), 64'(C_NOP));
    init_end_i = 1'b1; wr_len_i = 11'd0;
    repeat (10) @(posedge clk_i);
    #1;
    check("len0_busy", 64'(busy_o), 64'd0);
    check("len0_done", 64'(wr_done_o), 64'd0);
    wr_req_i = 1'b0;

    // Single-page bursts and page/row/bank splits.
    a0 = ack_total;
    issue(2'd1, 13'h010, 9'h000, 8, 1'b0, d1);
    wait_drain("t1_drain", 200);
    check("t1_acks", 64'(ack_total - a0), 64'd8);
    @(posedge clk_i); #1;
    check("t1_busy_after", 64'(busy_o), 64'd0);
    check("t1_done_after", 64'(wr_done_o), 64'd0);

    a0 = ack_total;
    issue(2'd0, 13'h005, 9'h1FC, 8, 1'b0, d1);
    wait_drain("t2_drain", 200);
    check("t2_acks", 64'(ack_total - a0), 64'd8);

    a0 = ack_total;
    issue(2'd1, 13'h1FFF, 9'h1FF, 2, 1'b0, d1);
    wait_drain("t3_drain", 200);
    check("t3_acks", 64'(ack_total - a0), 64'd2);

    a0 = ack_total;
    issue(2'd3, 13'h1FFF, 9'h1FF, 3, 1'b0, d1);
    wait_drain("bank_wrap_drain", 200);
    check("bank_wrap_acks", 64'(ack_total - a0), 64'd3);

    // Reset during DATA: three words consumed, two seen on DQ before the abort.
    repeat (2) @(posedge clk_i);
    #1;
    a0 = ack_total;
    wr_addr_i = {2'd2, 13'h0AA, 9'h010}; wr_len_i = 11'd8; wr_req_i = 1'b1;
    e_edge = cyc + 1;
    exp_q.push_back(mk(e_edge + 1, C_ACT, 2'd2, 13'h0AA, 1'b0, 16'h0, 1'b0));
    exp_q.push_back(mk(e_edge + TRCD + 1, C_WR, 2'd2, 13'h010, 1'b1, exp_word, 1'b0));
    exp_q.push_back(mk(e_edge + TRCD + 2, C_NOP, 2'b11, 13'h1FFF, 1'b1, exp_word + 16'd1, 1'b0));
    exp_word += 16'd3;
    @(posedge clk_i); #1;
    wr_req_i = 1'b0;
    while (cyc != e_edge + TRCD + 3) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check("midrst_trace", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("midrst_acks", 64'(ack_total - a0), 64'd3);
    a0 = ack_total;
    issue(2'd2, 13'h0AA, 9'h010, 4, 1'b0, d1);
    wait_drain("t5_restart_drain", 200);
    check("t5_restart_acks", 64'(ack_total - a0), 64'd4);

    // Full page with wr_req held: back-to-back requests, next ACTIVE two cycles after wr_done.
    a0 = ack_total;
    issue(2'd0, 13'h100, 9'h000, 512, 1'b1, d1);
    model_req(2'd0, 13'h100, 9'h000, 512, d1 + 1, d2);
    while (cyc < d1 + 1) begin
      @(posedge clk_i); #1;
    end
    wr_req_i = 1'b0;
    wait_drain("t6_drain", 2000);
    check("t6_acks", 64'(ack_total - a0), 64'd1024);
    repeat (5) @(posedge clk_i);
    #1;
    check("final_busy", 64'(busy_o), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
